uart_hex_tx_manager: RTL and testbench

Output-side counterpart of UART_Input_Manager. It takes a DIGIT_COUNT-digit hex result from the main automaton and sends it over an integrated 8N1 UART transmitter. The value goes out as uppercase ASCII hex, most significant digit first, followed by CR LF. A host terminal, or UART_Input_Manager in loopback, can parse the output directly.

---
 rtl/uart_hex_tx_manager.sv | 133 +++++++++++++
 tb/tb_uart_hex_tx_manager.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx_manager.sv
// Sends a DIGIT_COUNT-digit value as uppercase ASCII hex, MSB first, then CR LF,
// on an integrated 8N1 UART transmitter. Supports zero-gap back-to-back frames.
module uart_hex_tx_manager #(
    parameter int unsigned CLOCK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DIGIT_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGIT_COUNT*4-1:0] in,
    input  logic                     ready_in,
    output logic                     busy,
    output logic                     done,
    output logic                     RsTx
);

    localparam int unsigned BitTicks = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned BaudW    = (BitTicks > 1) ? $clog2(BitTicks) : 1;
    localparam int unsigned CharW    = $clog2(DIGIT_COUNT + 2);
    localparam int unsigned W        = DIGIT_COUNT * 4;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(BitTicks - 1);
    localparam logic [CharW-1:0] CharLast = CharW'(DIGIT_COUNT + 1);
    localparam logic [CharW-1:0] CharCr   = CharW'(DIGIT_COUNT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [CharW-1:0] char_q, char_d;
    logic [W-1:0]     data_q, data_d;
    logic             done_q, done_d;

    logic [3:0] nibble;
    logic [7:0] digit_char;
    logic [7:0] cur_char;
    logic       tick_end;
    logic       frame_end;
    logic       accept;

    // The current digit always sits in the top nibble; it is shifted up after each character.
    assign nibble     = data_q[W-1 -: 4];
    assign digit_char = (nibble < 4'd10) ? {4'h3, nibble} : 8'h37 + {4'h0, nibble};
    assign cur_char   = (char_q < CharCr) ? digit_char : ((char_q == CharCr) ? 8'h0D : 8'h0A);

    assign tick_end  = (baud_q == BaudLast);
    assign frame_end = (state_q == StStop) && tick_end && (char_q == CharLast);
    // Accepting on the final stop tick lets the next start bit follow with no idle gap.
    assign accept    = ready_in && ((state_q == StIdle) || frame_end);

    always_comb begin
        state_d = state_q;
        baud_d  = tick_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        char_d  = char_q;
        data_d  = data_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
            end
            StStart: begin
                if (tick_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (tick_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick_end) begin
                    if (char_q != CharLast) begin
                        char_d  = char_q + 1'b1;
                        data_d  = data_q << 4;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StStart;
            data_d  = in;
            char_d  = '0;
            baud_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

    always_comb begin
        RsTx = 1'b1;
        unique case (state_q)
            StIdle:  RsTx = 1'b1;
            StStart: RsTx = 1'b0;
            StData:  RsTx = cur_char[bit_q];
            StStop:  RsTx = 1'b1;
            default: RsTx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_tx_manager.sv
// Directed bench for uart_hex_tx_manager with BIT_TICKS=10, DIGIT_COUNT=4 (600-cycle frames).
module tb_uart_hex_tx_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        ready_in;
    logic        busy;
    logic        done;
    logic        RsTx;

    int n_vec = 0;
    int n_err = 0;

    uart_hex_tx_manager #(
        .CLOCK_RATE (1000),
        .BAUD_RATE  (100),
        .DIGIT_COUNT(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .ready_in(ready_in),
        .busy    (busy),
        .done    (done),
        .RsTx    (RsTx)
    );

    always #5 clk = ~clk;

    // Records one 600-cycle frame; first sample is taken at the current negedge (just after edge k).
    // Optionally raises ready_in with raise_val at sample raise_at, dropping it one sample later.
    task automatic capture(input int raise_at, input logic [15:0] raise_val,
                           output logic [47:0] chars, output int width_err,
                           output int framing_err, output int busy_cnt, output int done_cnt);
        logic s [600];
        chars       = '0;
        width_err   = 0;
        framing_err = 0;
        busy_cnt    = 0;
        done_cnt    = 0;
        for (int t = 0; t < 600; t++) begin
            s[t] = RsTx;
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) done_cnt++;
            if (t == raise_at) begin
                ready_in = 1'b1;
                in       = raise_val;
            end else if (t == raise_at + 1) begin
                ready_in = 1'b0;
            end
            if (t < 599) @(negedge clk);
        end
        for (int c = 0; c < 6; c++) begin
            for (int b = 0; b < 10; b++) begin
                int base;
                base = (c * 10 + b) * 10;
                for (int j = 1; j < 10; j++) begin
                    if (s[base + j] !== s[base]) width_err++;
                end
                if (b == 0 && s[base] !== 1'b0) framing_err++;
                if (b == 9 && s[base] !== 1'b1) framing_err++;
                if (b >= 1 && b <= 8) chars[(5 - c) * 8 + (b - 1)] = s[base];
            end
        end
    endtask

    task automatic start_frame(input logic [15:0] v);
        @(negedge clk);
        ready_in = 1'b1;
        in       = v;
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    task automatic test_reset;
        int toggles, busy_seen;
        reset    = 1'b1;
        ready_in = 1'b0;
        in       = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (RsTx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: RsTx/busy/done=%b%b%b want 100", RsTx, busy, done);
        end
        reset     = 1'b0;
        toggles   = 0;
        busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (RsTx !== 1'b1) toggles++;
            if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
        end
        n_vec++;
        if (toggles != 0 || busy_seen != 0) begin
            n_err++;
            $display("FAIL reset_idle: low RsTx cycles=%0d busy/done cycles=%0d want 0/0",
                     toggles, busy_seen);
        end
    endtask

    task automatic test_basic_frame;
        logic [47:0] ch;
        int we, fe, bc, dc;
        start_frame(16'h1A2F);
        capture(-10, 16'h0, ch, we, fe, bc, dc);
        n_vec++;
        if (ch !== 48'h314132460D0A) begin
            n_err++;
            $display("FAIL basic_chars: got %h want 314132460d0a", ch);
        end
        n_vec++;
        if (we != 0 || fe != 0) begin
            n_err++;
            $display("FAIL basic_bit_width: width_err=%0d framing_err=%0d want 0/0", we, fe);
        end
        n_vec++;
        if (bc != 600 || dc != 0) begin
            n_err++;
            $display("FAIL basic_busy: busy cycles=%0d early done=%0d want 600/0", bc, dc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || RsTx !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done: done/busy/RsTx=%b%b%b want 101", done, busy, RsTx);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_busy_drop;
        logic [47:0] ch;
        int we, fe, bc, dc, extra;
        start_frame(16'h0000);
        capture(136, 16'hFFFF, ch, we, fe, bc, dc);
        n_vec++;
        if (ch !== 48'h303030300D0A || we != 0 || fe != 0) begin
            n_err++;
            $display("FAIL drop_chars: got %h (we=%0d fe=%0d) want 303030300d0a", ch, we, fe);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_done: done/busy=%b%b want 10", done, busy);
        end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || RsTx !== 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL drop_no_second: active cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] ch;
        int we, fe, bc, dc;
        start_frame(16'hBEEF);
        capture(599, 16'h9B0C, ch, we, fe, bc, dc);
        n_vec++;
        if (ch !== 48'h424545460D0A || we != 0 || fe != 0) begin
            n_err++;
            $display("FAIL b2b_first: got %h (we=%0d fe=%0d) want 424545460d0a", ch, we, fe);
        end
        @(negedge clk);
        ready_in = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1 || RsTx !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: done/busy/RsTx=%b%b%b want 110", done, busy, RsTx);
        end
        in = 16'h1234;
        capture(-10, 16'h0, ch, we, fe, bc, dc);
        n_vec++;
        if (ch !== 48'h394230430D0A || we != 0 || fe != 0 || bc != 600) begin
            n_err++;
            $display("FAIL b2b_second: got %h (we=%0d fe=%0d busy=%0d) want 394230430d0a",
                     ch, we, fe, bc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done: done/busy=%b%b want 10", done, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [47:0] ch;
        int we, fe, bc, dc, stray;
        start_frame(16'h5555);
        repeat (234) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (RsTx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: RsTx/busy/done=%b%b%b want 100", RsTx, busy, done);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || RsTx !== 1'b1) stray++;
        end
        n_vec++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL midreset_quiet: active cycles=%0d want 0", stray);
        end
        // Reset and strobe in the same cycle: the strobe must be dropped.
        @(negedge clk);
        reset    = 1'b1;
        ready_in = 1'b1;
        in       = 16'hAAAA;
        @(negedge clk);
        reset    = 1'b0;
        ready_in = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || RsTx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_wins: busy/RsTx=%b%b want 01", busy, RsTx);
        end
        start_frame(16'h00C3);
        in = 16'hFFFF;
        capture(-10, 16'h0, ch, we, fe, bc, dc);
        n_vec++;
        if (ch !== 48'h303043330D0A || we != 0 || fe != 0 || bc != 600) begin
            n_err++;
            $display("FAIL midreset_clean: got %h (we=%0d fe=%0d busy=%0d) want 303043330d0a",
                     ch, we, fe, bc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_done: done=%b want 1", done);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ready_in = 1'b0;
        in       = 16'h0;
        test_reset();
        test_basic_frame();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
